// File: rtl/bus_arbiter_split_n_pkg.sv
// Shared types and helpers for the split-transaction bus arbiter.
// Imported by the arbiter top and its round-robin picker.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT_INIT  = 2'd1,
        GRANT_SPLIT = 2'd2
    } arb_state_e;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int onehot_to_idx(input logic [7:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_split_n_rr_picker.sv
// Combinational picker: fixed priority or round-robin from a pointer.
// The doubled vector wraps the search past the top index.
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int PTR_W = clog2_min1(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             mode,
    output logic [WIDTH-1:0] pick,
    output logic             valid
);

    logic [WIDTH-1:0]   mask;
    logic [2*WIDTH-1:0] dbl;
    logic               found;

    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = !mode || (PTR_W'(i) >= ptr);
        end
        dbl   = {req, req & mask};
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!found && dbl[i]) begin
                found   = 1'b1;
                pick[i] = 1'b1;
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (!found && dbl[WIDTH+i]) begin
                found   = 1'b1;
                pick[i] = 1'b1;
            end
        end
        valid = |req;
    end

endmodule

// File: rtl/bus_arbiter_split_n.sv
// N-initiator serial-bus arbiter with split-transaction parking.
// A split target returning data is granted together with its parked initiator.
module bus_arbiter_split_n
    import bus_arb_pkg::*;
#(
    parameter int NUM_INIT  = 4,
    parameter int NUM_SPLIT = 1,
    parameter int RR_MODE   = 1,
    localparam int INIT_W   = clog2_min1(NUM_INIT),
    localparam int SPLIT_W  = clog2_min1(NUM_SPLIT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_INIT-1:0]  req,
    input  logic [NUM_SPLIT-1:0] split_req,
    input  logic [NUM_SPLIT-1:0] split_ack,
    output logic [NUM_INIT-1:0]  grant,
    output logic [NUM_SPLIT-1:0] grant_split,
    output logic [INIT_W-1:0]    sel,
    output logic [SPLIT_W-1:0]   split_sel,
    output logic                 bus_busy,
    output logic [NUM_SPLIT-1:0] split_pending,
    output logic                 proto_err
);

    arb_state_e state_q, state_d;

    logic [INIT_W-1:0]  owner_q, owner_d;
    logic [INIT_W-1:0]  ptr_q, ptr_d;
    logic [SPLIT_W-1:0] tgt_q, tgt_d;

    logic [NUM_SPLIT-1:0][INIT_W-1:0] parked_q, parked_d;
    logic [NUM_SPLIT-1:0] pend_d;

    logic [NUM_INIT-1:0]  parked_mask, eligible, pick, owner_oh;
    logic [NUM_SPLIT-1:0] split_go, split_oh, tgt_oh;
    logic [INIT_W-1:0]    pick_idx, split_owner;
    logic [SPLIT_W-1:0]   split_idx;
    logic                 pick_vld, ack_one, ack_ok, req_owner, err_d;

    logic [NUM_INIT-1:0]  grant_d;
    logic [NUM_SPLIT-1:0] gsplit_d;

    rr_picker #(
        .WIDTH (NUM_INIT)
    ) u_pick (
        .req   (eligible),
        .ptr   (ptr_q),
        .mode  (RR_MODE != 0),
        .pick  (pick),
        .valid (pick_vld)
    );

    always_comb begin
        parked_mask = '0;
        split_oh    = '0;
        split_owner = '0;
        split_go    = split_req & split_pending;
        for (int k = 0; k < NUM_SPLIT; k++) begin
            for (int i = 0; i < NUM_INIT; i++) begin
                if (split_pending[k] && parked_q[k] == INIT_W'(i))
                    parked_mask[i] = 1'b1;
            end
        end
        // Descending scan so the lowest returning target wins.
        for (int k = NUM_SPLIT - 1; k >= 0; k--) begin
            if (split_go[k]) begin
                split_oh    = '0;
                split_oh[k] = 1'b1;
                split_owner = parked_q[k];
            end
        end
        for (int i = 0; i < NUM_INIT; i++)
            owner_oh[i] = (owner_q == INIT_W'(i));
        for (int k = 0; k < NUM_SPLIT; k++)
            tgt_oh[k] = (tgt_q == SPLIT_W'(k));
    end

    assign eligible  = req & ~parked_mask;
    assign pick_idx  = INIT_W'(onehot_to_idx(8'(pick)));
    assign split_idx = SPLIT_W'(onehot_to_idx(8'(split_oh)));
    assign req_owner = |(req & owner_oh);
    assign ack_one   = $onehot(split_ack);
    assign ack_ok    = (state_q == GRANT_INIT) && ack_one &&
                       !(|(split_ack & split_pending));

    assign err_d = ($countones(split_ack) > 1) ||
                   ((|split_ack) && (state_q != GRANT_INIT)) ||
                   ((state_q == GRANT_INIT) && ack_one &&
                    (|(split_ack & split_pending))) ||
                   ((state_q == IDLE) && (|(split_req & ~split_pending)));

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        tgt_d    = tgt_q;
        ptr_d    = ptr_q;
        pend_d   = split_pending;
        parked_d = parked_q;
        unique case (state_q)
            IDLE: begin
                if (|split_go) begin
                    state_d = GRANT_SPLIT;
                    tgt_d   = split_idx;
                    owner_d = split_owner;
                end else if (pick_vld) begin
                    state_d = GRANT_INIT;
                    owner_d = pick_idx;
                    ptr_d   = (pick_idx == INIT_W'(NUM_INIT - 1)) ?
                              '0 : pick_idx + INIT_W'(1);
                end
            end
            GRANT_INIT: begin
                if (ack_ok) begin
                    state_d = IDLE;
                    pend_d  = split_pending | split_ack;
                    for (int k = 0; k < NUM_SPLIT; k++) begin
                        if (split_ack[k]) parked_d[k] = owner_q;
                    end
                end else if (!req_owner) begin
                    state_d = IDLE;
                end
            end
            GRANT_SPLIT: begin
                if (!(|(split_req & tgt_oh))) begin
                    state_d = IDLE;
                    pend_d  = split_pending & ~tgt_oh;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are a registered image of the next state.
    always_comb begin
        grant_d  = '0;
        gsplit_d = '0;
        for (int i = 0; i < NUM_INIT; i++)
            grant_d[i] = (state_d != IDLE) && (owner_d == INIT_W'(i));
        for (int k = 0; k < NUM_SPLIT; k++)
            gsplit_d[k] = (state_d == GRANT_SPLIT) && (tgt_d == SPLIT_W'(k));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            tgt_q         <= '0;
            ptr_q         <= '0;
            parked_q      <= '0;
            split_pending <= '0;
            grant         <= '0;
            grant_split   <= '0;
            sel           <= '0;
            split_sel     <= '0;
            bus_busy      <= 1'b0;
            proto_err     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            tgt_q         <= tgt_d;
            ptr_q         <= ptr_d;
            parked_q      <= parked_d;
            split_pending <= pend_d;
            grant         <= grant_d;
            grant_split   <= gsplit_d;
            sel           <= (state_d != IDLE) ? owner_d : '0;
            split_sel     <= (state_d == GRANT_SPLIT) ? tgt_d : '0;
            bus_busy      <= (state_d != IDLE);
            proto_err     <= err_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_split_n.sv
// Scoreboard bench for bus_arbiter_split_n: a round-robin instance
// carries the split scenarios, a fixed-priority instance the priority test.
module tb_bus_arbiter_split_n;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       gs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [0:0] split_req = '0;
    logic [0:0] split_ack = '0;
    logic [3:0] grant;
    logic [0:0] grant_split;
    logic [1:0] sel;
    logic [0:0] split_sel;
    logic       bus_busy;
    logic [0:0] split_pending;
    logic       proto_err;

    logic [3:0] req_fp = '0;
    logic [0:0] fp_sreq = '0;
    logic [0:0] fp_sack = '0;
    logic [3:0] grant_fp;
    logic [0:0] gs_fp;
    logic [1:0] sel_fp;
    logic [0:0] ss_fp;
    logic       busy_fp;
    logic [0:0] pend_fp;
    logic       err_fp;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;

    bus_arbiter_split_n #(
        .NUM_INIT(4), .NUM_SPLIT(1), .RR_MODE(1)
    ) u_rr (
        .clk(clk), .rst(rst), .req(req),
        .split_req(split_req), .split_ack(split_ack),
        .grant(grant), .grant_split(grant_split),
        .sel(sel), .split_sel(split_sel),
        .bus_busy(bus_busy), .split_pending(split_pending),
        .proto_err(proto_err)
    );

    bus_arbiter_split_n #(
        .NUM_INIT(4), .NUM_SPLIT(1), .RR_MODE(0)
    ) u_fp (
        .clk(clk), .rst(rst), .req(req_fp),
        .split_req(fp_sreq), .split_ack(fp_sack),
        .grant(grant_fp), .grant_split(gs_fp),
        .sel(sel_fp), .split_sel(ss_fp),
        .bus_busy(busy_fp), .split_pending(pend_fp),
        .proto_err(err_fp)
    );

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (grant !== 4'b0000) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({grant, grant_split, sel, split_sel, bus_busy,
             split_pending, proto_err} !== 11'd0) begin
            errors++;
            $display("FAIL reset_rr: got grant=%b gs=%b sel=%0d busy=%b pend=%b err=%b expected all 0",
                     grant, grant_split, sel, bus_busy, split_pending, proto_err);
        end
        checks++;
        if ({grant_fp, gs_fp, sel_fp, ss_fp, busy_fp,
             pend_fp, err_fp} !== 11'd0) begin
            errors++;
            $display("FAIL reset_fp: got grant=%b sel=%0d busy=%b expected all 0",
                     grant_fp, sel_fp, busy_fp);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0000 || bus_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got grant=%b busy=%b expected 0000/0",
                     grant, bus_busy);
        end
    endtask

    task automatic test_fixed_priority();
        req_fp = 4'b1010;
        exp_q.push_back('{grant: 4'b0010, sel: 2'd1, gs: 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (grant_fp !== e.grant || sel_fp !== e.sel) begin
            errors++;
            $display("FAIL fp_first: got grant=%b sel=%0d expected grant=%b sel=%0d",
                     grant_fp, sel_fp, e.grant, e.sel);
        end
        @(negedge clk);
        req_fp = 4'b1000;
        exp_q.push_back('{grant: 4'b1000, sel: 2'd3, gs: 1'b0});
        @(negedge clk);
        checks++;
        if (grant_fp !== 4'b0000 || busy_fp !== 1'b0) begin
            errors++;
            $display("FAIL fp_gap: got grant=%b busy=%b expected 0000/0",
                     grant_fp, busy_fp);
        end
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (grant_fp !== e.grant || sel_fp !== e.sel) begin
            errors++;
            $display("FAIL fp_second: got grant=%b sel=%0d expected grant=%b sel=%0d",
                     grant_fp, sel_fp, e.grant, e.sel);
        end
        req_fp = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        bit ok;
        req = 4'b1111;
        for (int n = 0; n < 5; n++)
            exp_q.push_back('{grant: 4'(1 << order[n]),
                              sel: 2'(order[n]), gs: 1'b0});
        for (int n = 0; n < 5; n++) begin
            wait_grant(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rr_timeout: got no grant for slot %0d expected grant within 20 cycles", n);
            end
            e = exp_q.pop_front();
            checks++;
            if (grant !== e.grant || sel !== e.sel) begin
                errors++;
                $display("FAIL rr_order: slot %0d got grant=%b sel=%0d expected grant=%b sel=%0d",
                         n, grant, sel, e.grant, e.sel);
            end
            repeat (2) @(negedge clk);
            req[order[n]] = 1'b0;
            @(negedge clk);
            checks++;
            if (grant !== 4'b0000) begin
                errors++;
                $display("FAIL rr_gap: slot %0d got grant=%b expected 0000",
                         n, grant);
            end
            if (n < 4) req[order[n]] = 1'b1;
            else req = 4'b0000;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_split();
        req = 4'b0100;
        exp_q.push_back('{grant: 4'b0100, sel: 2'd2, gs: 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (grant !== e.grant || sel !== e.sel) begin
            errors++;
            $display("FAIL split_owner: got grant=%b sel=%0d expected grant=%b sel=%0d",
                     grant, sel, e.grant, e.sel);
        end
        split_ack = 1'b1;
        @(negedge clk);
        split_ack = 1'b0;
        checks++;
        if (split_pending !== 1'b1 || grant !== 4'b0000 ||
            proto_err !== 1'b0) begin
            errors++;
            $display("FAIL split_park: got pend=%b grant=%b err=%b expected 1/0000/0",
                     split_pending, grant, proto_err);
        end
        req = 4'b0101;
        exp_q.push_back('{grant: 4'b0001, sel: 2'd0, gs: 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (grant !== e.grant || sel !== e.sel) begin
            errors++;
            $display("FAIL split_masked_win: got grant=%b sel=%0d expected grant=%b sel=%0d",
                     grant, sel, e.grant, e.sel);
        end
        req = 4'b0100;
        repeat (2) @(negedge clk);
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL split_masked: got grant=%b expected 0000", grant);
        end
        split_req = 1'b1;
        exp_q.push_back('{grant: 4'b0100, sel: 2'd2, gs: 1'b1});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (grant !== e.grant || sel !== e.sel || grant_split !== e.gs ||
            split_sel !== 1'b0 || bus_busy !== 1'b1) begin
            errors++;
            $display("FAIL split_return: got grant=%b sel=%0d gs=%b busy=%b expected grant=%b sel=%0d gs=%b busy=1",
                     grant, sel, grant_split, bus_busy, e.grant, e.sel, e.gs);
        end
        @(negedge clk);
        split_req = 1'b0;
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (split_pending !== 1'b0 || grant !== 4'b0000 ||
            grant_split !== 1'b0) begin
            errors++;
            $display("FAIL split_release: got pend=%b grant=%b gs=%b expected 0/0000/0",
                     split_pending, grant, grant_split);
        end
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        req = 4'b0010;
        exp_q.push_back('{grant: 4'b0010, sel: 2'd1, gs: 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (grant !== e.grant || sel !== e.sel) begin
            errors++;
            $display("FAIL simul_owner: got grant=%b sel=%0d expected grant=%b sel=%0d",
                     grant, sel, e.grant, e.sel);
        end
        split_ack = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        split_ack = 1'b0;
        checks++;
        if (split_pending !== 1'b1 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL simul_park: got pend=%b err=%b expected 1/0",
                     split_pending, proto_err);
        end
        split_req = 1'b1;
        req = 4'b0001;
        exp_q.push_back('{grant: 4'b0010, sel: 2'd1, gs: 1'b1});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (grant !== e.grant || sel !== e.sel || grant_split !== e.gs) begin
            errors++;
            $display("FAIL simul_split_first: got grant=%b sel=%0d gs=%b expected grant=%b sel=%0d gs=%b",
                     grant, sel, grant_split, e.grant, e.sel, e.gs);
        end
        split_req = 1'b0;
        exp_q.push_back('{grant: 4'b0001, sel: 2'd0, gs: 1'b0});
        @(negedge clk);
        checks++;
        if (grant !== 4'b0000 || split_pending !== 1'b0) begin
            errors++;
            $display("FAIL simul_release: got grant=%b pend=%b expected 0000/0",
                     grant, split_pending);
        end
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (grant !== e.grant || sel !== e.sel) begin
            errors++;
            $display("FAIL simul_then_init: got grant=%b sel=%0d expected grant=%b sel=%0d",
                     grant, sel, e.grant, e.sel);
        end
        req = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_proto_err();
        split_req = 1'b1;
        @(negedge clk);
        checks++;
        if (proto_err !== 1'b1 || grant_split !== 1'b0 ||
            split_pending !== 1'b0 || bus_busy !== 1'b0) begin
            errors++;
            $display("FAIL perr_sreq: got err=%b gs=%b pend=%b busy=%b expected 1/0/0/0",
                     proto_err, grant_split, split_pending, bus_busy);
        end
        split_req = 1'b0;
        @(negedge clk);
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL perr_sreq_pulse: got err=%b expected 0", proto_err);
        end
        split_ack = 1'b1;
        @(negedge clk);
        split_ack = 1'b0;
        checks++;
        if (proto_err !== 1'b1 || split_pending !== 1'b0) begin
            errors++;
            $display("FAIL perr_sack: got err=%b pend=%b expected 1/0",
                     proto_err, split_pending);
        end
        @(negedge clk);
        checks++;
        if (proto_err !== 1'b0 || bus_busy !== 1'b0) begin
            errors++;
            $display("FAIL perr_sack_pulse: got err=%b busy=%b expected 0/0",
                     proto_err, bus_busy);
        end
    endtask

    task automatic test_reset_mid_split();
        req = 4'b0100;
        exp_q.push_back('{grant: 4'b0100, sel: 2'd2, gs: 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (grant !== e.grant || sel !== e.sel) begin
            errors++;
            $display("FAIL rst_owner: got grant=%b sel=%0d expected grant=%b sel=%0d",
                     grant, sel, e.grant, e.sel);
        end
        split_ack = 1'b1;
        @(negedge clk);
        split_ack = 1'b0;
        split_req = 1'b1;
        exp_q.push_back('{grant: 4'b0100, sel: 2'd2, gs: 1'b1});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (grant !== e.grant || grant_split !== e.gs) begin
            errors++;
            $display("FAIL rst_split_grant: got grant=%b gs=%b expected grant=%b gs=%b",
                     grant, grant_split, e.grant, e.gs);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0000 || grant_split !== 1'b0 ||
            split_pending !== 1'b0 || bus_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got grant=%b gs=%b pend=%b busy=%b expected all 0",
                     grant, grant_split, split_pending, bus_busy);
        end
        split_req = 1'b0;
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0001;
        exp_q.push_back('{grant: 4'b0001, sel: 2'd0, gs: 1'b0});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (grant !== e.grant || sel !== e.sel) begin
            errors++;
            $display("FAIL rst_regrant: got grant=%b sel=%0d expected grant=%b sel=%0d",
                     grant, sel, e.grant, e.sel);
        end
        req = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_split();
        test_simultaneous();
        test_proto_err();
        test_reset_mid_split();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end before 200000");
        $fatal(1);
    end

endmodule

// File: doc/bus_arbiter_split_n.md
Name: bus_arbiter_split_n

Overview:
- N-initiator, S-split-target serial-bus arbiter with split-transaction tracking.
- Grants the serial bus to one initiator at a time, using fixed-priority or round-robin selection.
- When a target splits a transaction, records which initiator was parked on that target. When the target later requests the bus, grants the target and the parked initiator together.
- Replaces the fixed two-initiator/one-split arbiter in the bus top level.

Parameters:
NUM_INIT, 4, number of initiators (2..8)
NUM_SPLIT, 1, number of split-capable targets (1..4)
RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
INIT_W, max(1,$clog2(NUM_INIT)), derived localparam; width of the initiator index
SPLIT_W, max(1,$clog2(NUM_SPLIT)), derived localparam; width of the target index

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  reset, asynchronous, active-high
req  in  NUM_INIT  per-initiator bus request, level
split_req  in  NUM_SPLIT  per-target request to return split data, level
split_ack  in  NUM_SPLIT  one-cycle pulse from a target port: current transaction split
grant  out  NUM_INIT  one-hot initiator grant, registered
grant_split  out  NUM_SPLIT  one-hot split-target grant, registered
sel  out  INIT_W  index of the initiator owning the bus; mux select
split_sel  out  SPLIT_W  index of the granted split target
bus_busy  out  1  high in any grant state
split_pending  out  NUM_SPLIT  target k holds a parked initiator
proto_err  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; RR pointer 0; parked table cleared.
- All outputs are registered. Grant appears 1 cycle after req is sampled in IDLE.
- States:
  - IDLE: bus free.
  - GRANT_INIT: owner = registered initiator index.
  - GRANT_SPLIT: owner = parked[k], target = k.
- IDLE transitions, in priority order:
  1. Any split_req[k] with split_pending[k] set: go to GRANT_SPLIT; lowest k wins.
  2. Otherwise, any eligible req: go to GRANT_INIT. Eligible = req & ~parked_mask, where parked_mask covers every initiator recorded in a pending entry.
     - RR_MODE=1: search starts at the RR pointer. Pointer = last granted index+1, mod NUM_INIT.
     - RR_MODE=0: lowest index wins.
  3. Otherwise stay in IDLE.
- GRANT_INIT:
  - Drive grant[owner]=1, sel=owner, bus_busy=1.
  - split_ack[k] pulse with split_pending[k]=0: set parked[k]=owner and split_pending[k]=1, then go to IDLE.
  - Else req[owner]=0: go to IDLE.
  - split_ack takes precedence over a same-cycle req drop.
- GRANT_SPLIT:
  - Drive grant_split[k]=1, grant[parked[k]]=1, sel=parked[k], split_sel=k, bus_busy=1.
  - split_req[k]=0: clear split_pending[k], go to IDLE.
  - Initiator req is ignored in this state.
- Bus turnaround: every return to IDLE costs exactly one cycle with all grants low. Back-to-back grants are never adjacent.
- Parked initiators: their req is masked until their entry clears. They may hold req high throughout.
  - An initiator can be parked on at most one target.
  - Distinct targets may hold distinct initiators at the same time.
- proto_err is pulsed, and the offending event is otherwise ignored, on any of:
  - split_ack outside GRANT_INIT;
  - split_ack to a target already pending;
  - more than one split_ack bit set;
  - split_req[k] high in IDLE with split_pending[k]=0.
- Reset mid-grant drops all grants asynchronously and clears all parked state. Pending splits are lost.
- Single requester under RR: re-granted after the one-cycle gap, so no starvation.

Decomposition:
- Package bus_arb_pkg holds:
  - state enum arb_state_e (IDLE, GRANT_INIT, GRANT_SPLIT);
  - function onehot_to_idx;
  - localparam helper clog2_min1.
- Sub-module rr_picker (combinational, parameter WIDTH):
  - inputs: request vector, pointer, mode;
  - outputs: one-hot pick and valid.
  - Implemented as a double-width masked priority search.
- The arbiter instantiates one rr_picker for initiators. Split-target selection uses fixed priority inline.

Test Plan:
- Fixed priority, NUM_INIT=4, RR_MODE=0: req=4'b1010 held.
  - grant=4'b0010 one cycle after sampling, sel=1.
  - Drop req[1]: one idle cycle, then grant=4'b1000, sel=3.
- Round-robin: req=4'b1111 held; each owner drops req after 3 cycles.
  - Grant order 0,1,2,3,0, with one all-zero cycle between grants.
- Split: initiator 2 granted; split_ack=1'b1 pulse.
  - split_pending=1; grant low next cycle.
  - req[2] stays high but is masked; initiator 0 then wins.
  - After initiator 0 releases, split_req=1: grant_split=1, grant=4'b0100, sel=2.
  - split_req drop: split_pending=0.
- Simultaneous events: split_ack and req[owner] drop in the same cycle -> parked entry recorded.
  - split_req and req[0] both high in IDLE -> GRANT_SPLIT first.
- Protocol errors, each gives a one-cycle proto_err pulse with no state change:
  - split_req asserted with nothing pending;
  - split_ack asserted in IDLE.
- Reset asserted during GRANT_SPLIT -> all grants and split_pending go to 0 immediately, without waiting for a clock edge.
  - After reset release, req=4'b0001 -> grant=4'b0001.
